bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
Sequential binary-to-packed-BCD converter (shift-and-add-3, one shift per clock) directly upstream of the 8-digit seven-segment display driver. Accepts an unsigned binary value on a start pulse and produces DIGITS packed BCD nibbles on a 32-bit bus for the display's data input. Saturates to all nines on overflow. The result holds steady between conversions, so the display scans a stable value.

Parameters:
BIN_W, 27, width of binary input; 27 covers 0..99,999,999 plus overflow range.
DIGITS, 8, number of BCD digits produced; bcd width = 4*DIGITS.

Ports:
clk  in  1  system clock; all state changes on rising edge.
rs_n  in  1  reset, asynchronous, active-low.
bin  in  BIN_W  unsigned binary value; sampled only on the edge that accepts start.
start  in  1  request conversion; level-sampled each edge.
busy  out  1  high while a conversion is in progress.
done  out  1  one-cycle pulse when bcd/ovf update.
bcd  out  4*DIGITS  packed BCD result; digit 0 (least significant) in [3:0]; feeds the display data input.
ovf  out  1  high when the last accepted bin exceeded 10^DIGITS-1.

Behaviour:
- Reset (rs_n low, asynchronous): state IDLE, bcd = 0, ovf = 0, done = 0, busy = 0, shift counter = 0, working regs = 0. Takes effect immediately, including mid-conversion; the in-flight conversion is discarded and bcd is not updated.
- States: IDLE, SHIFT, LATCH. busy = (state != IDLE), decoded combinationally from the state register.
- IDLE: at an edge with start=1, load bin_reg <= bin, work <= 0, cnt <= 0, ovf_pend <= (bin > 10^DIGITS-1), go SHIFT. start=0 stays IDLE.
- SHIFT, each edge:
  - Every work nibble >= 5 gets +3 (all nibbles in parallel, same cycle).
  - Then {work, bin_reg} shifts left 1; the bit leaving work's MSB is discarded.
  - cnt++. After the edge where cnt reaches BIN_W-1 (BIN_W shifts total), go LATCH.
- LATCH edge:
  - bcd <= ovf_pend ? all nibbles 4'h9 : work.
  - ovf <= ovf_pend; done <= 1; go IDLE.
- done is high for exactly one cycle and clears at the next edge.
- Latency: start sampled at edge E0; bcd/ovf/done update at edge E(BIN_W+1). That is 28 cycles at default BIN_W.
- Throughput: the edge after LATCH is in IDLE. A start present then is accepted, giving a back-to-back period of BIN_W+2 cycles.
- start while busy is ignored (no queuing); bin changes while busy have no effect.
- bcd and ovf hold their last values indefinitely between conversions. They are only written at LATCH or on reset.
- Arithmetic:
  - Nibble adjust is a 4-bit add with no carry out; inputs 5..9 map to 8..12, and larger values never occur when not overflowing.
  - The overflow comparison uses a BIN_W-bit compare against the constant 10^DIGITS-1. When BIN_W cannot represent that constant, ovf is tied 0.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package bin2bcd_pkg holds:
  - state encoding constants (IDLE=2'd0, SHIFT=2'd1, LATCH=2'd2);
  - default BIN_W and DIGITS;
  - BCD_MAX constant (10^DIGITS-1);
  - counter width derived from BIN_W.
- One natural sub-module: bcd_digit_adj, a combinational 4-bit "if >=4'd5 add 3". It is instantiated DIGITS times via a generate loop on the work nibbles.

Test Plan:
- bin=0, start 1 cycle -> busy high 28 cycles; done pulse at edge 28; bcd=32'h00000000, ovf=0.
- bin=12345678 -> bcd=32'h12345678, ovf=0; bcd unchanged for 100 cycles afterward with start=0.
- bin=99999999 -> bcd=32'h99999999, ovf=0; then bin=100000000 -> bcd=32'h99999999, ovf=1; then bin=59 -> bcd=32'h00000059, ovf=0.
- Back-to-back: start held high continuously with bin=7 then 805 -> done every 29 cycles; results 32'h00000007 then 32'h00000805. start pulses mid-conversion are ignored.
- Assert rs_n low at cycle 10 of a conversion of 4321 (previous bcd=32'h00000059) -> bcd=0, busy=0, done=0 immediately, with no done pulse. After release, start with bin=4321 -> 32'h00004321.
- Random sweep of 10k values 0..2^27-1 against a reference model -> bcd and ovf match; exactly one done per accepted start.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: state
// encoding, default sizing, the largest representable BCD value and the
// shift-counter width.
package bin2bcd_pkg;

   localparam int unsigned DEF_BIN_W  = 27;
   localparam int unsigned DEF_DIGITS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_e;

   // 10^digits - 1, i.e. the largest value that fits in `digits` BCD nibbles
   function automatic longint unsigned pow10_m1(input int unsigned digits);
      longint unsigned p;
      p = 64'd1;
      for (int unsigned i = 0; i < digits; i++) begin
         p = p * 64'd10;
      end
      return p - 64'd1;
   endfunction

   // Counter must hold BIN_W so the final shift count is representable
   function automatic int unsigned cnt_width(input int unsigned bin_w);
      return $clog2(bin_w + 1);
   endfunction

   localparam longint unsigned BCD_MAX = pow10_m1(DEF_DIGITS);
   localparam int unsigned     CNT_W   = cnt_width(DEF_BIN_W);

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake/data bundle between a conversion requester and bin2bcd_seq.
//   bin   : binary value to convert (sampled with start)
//   start : conversion request, level-sampled
//   busy  : conversion in progress
//   done  : one-cycle pulse when bcd/ovf update
//   bcd   : packed BCD result, digit 0 in [3:0]
//   ovf   : last accepted value exceeded the BCD range
interface bin2bcd_seq_if
   import bin2bcd_pkg::*;
#(
   parameter int unsigned BIN_W  = DEF_BIN_W,
   parameter int unsigned DIGITS = DEF_DIGITS
);

   logic [BIN_W-1:0]    bin;
   logic                start;
   logic                busy;
   logic                done;
   logic [4*DIGITS-1:0] bcd;
   logic                ovf;

   modport master (output bin, start, input busy, done, bcd, ovf);
   modport slave  (input bin, start, output busy, done, bcd, ovf);

endinterface

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// Double-dabble nibble correction: add 3 to a BCD digit that is 5 or more.
//   nib       : current working nibble
//   nib_adj_c : corrected nibble (combinational, 4-bit wrap)
module bcd_digit_adj (
   input  logic [3:0] nib,
   output logic [3:0] nib_adj_c
);

   always_comb begin
      nib_adj_c = (nib >= 4'd5) ? nib + 4'd3 : nib;
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-packed-BCD converter, one shift-and-add-3 step per
// clock. Saturates to all nines when the input exceeds the BCD range. The
// result and overflow flag hold between conversions.
//   clk  : system clock
//   rs_n : asynchronous active-low reset
//   bus  : slave side of bin2bcd_seq_if (bin/start in, busy/done/bcd/ovf out)
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int unsigned BIN_W  = DEF_BIN_W,
   parameter int unsigned DIGITS = DEF_DIGITS
) (
   input  logic           clk,
   input  logic           rs_n,
   bin2bcd_seq_if.slave   bus
);

   localparam int unsigned     BCD_W   = 4 * DIGITS;
   localparam int unsigned     CW      = cnt_width(BIN_W);
   localparam longint unsigned MAX_VAL = pow10_m1(DIGITS);
   // Overflow is only possible when BIN_W can exceed 10^DIGITS-1
   localparam bit              OVF_EN  = (BIN_W < 64) && (MAX_VAL < (64'd1 << BIN_W));

   state_e           state_q, state_n;
   logic [BIN_W-1:0] bin_q, bin_n;
   logic [BCD_W-1:0] work_q, work_n;
   logic [CW-1:0]    cnt_q, cnt_n;
   logic             ovf_pend_q, ovf_pend_n;
   logic [BCD_W-1:0] bcd_q, bcd_n;
   logic             ovf_q, ovf_n;
   logic             done_q, done_n;

   logic [BCD_W-1:0] work_adj_c;
   logic             ovf_in_c;

   // Range check of the incoming value
   if (OVF_EN) begin : g_ovf
      assign ovf_in_c = (bus.bin > BIN_W'(MAX_VAL));
   end else begin : g_no_ovf
      assign ovf_in_c = 1'b0;
   end

   // Per-digit add-3 correction on every working nibble in parallel
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .nib       (work_q[4*g +: 4]),
         .nib_adj_c (work_adj_c[4*g +: 4])
      );
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rs_n) begin
      if (!rs_n) begin
         state_q    <= IDLE;
         bin_q      <= '0;
         work_q     <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         bcd_q      <= '0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_n;
         bin_q      <= bin_n;
         work_q     <= work_n;
         cnt_q      <= cnt_n;
         ovf_pend_q <= ovf_pend_n;
         bcd_q      <= bcd_n;
         ovf_q      <= ovf_n;
         done_q     <= done_n;
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_n    = state_q;
      bin_n      = bin_q;
      work_n     = work_q;
      cnt_n      = cnt_q;
      ovf_pend_n = ovf_pend_q;
      bcd_n      = bcd_q;
      ovf_n      = ovf_q;
      done_n     = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               bin_n      = bus.bin;
               work_n     = '0;
               cnt_n      = '0;
               ovf_pend_n = ovf_in_c;
               state_n    = SHIFT;
            end
         end
         SHIFT: begin
            // The corrected top bit falls off the left end of work
            {work_n, bin_n} = {work_adj_c, bin_q} << 1;
            cnt_n           = cnt_q + CW'(1);
            if (cnt_q == CW'(BIN_W - 1)) begin
               state_n = LATCH;
            end
         end
         LATCH: begin
            bcd_n   = ovf_pend_q ? {DIGITS{4'h9}} : work_q;
            ovf_n   = ovf_pend_q;
            done_n  = 1'b1;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.done = done_q;
   assign bus.bcd  = bcd_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: reset values, latency and
// busy window, hold behaviour, saturation, back-to-back throughput,
// mid-conversion reset, and a short random sweep against a decimal model.
module tb_bin2bcd_seq;

   localparam int unsigned BIN_W  = 27;
   localparam int unsigned DIGITS = 8;

   logic clk;
   logic rs_n;
   int   tests;
   int   fails;

   bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

   bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk  (clk),
      .rs_n (rs_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Decimal reference: digit-by-digit division, saturating above 99,999,999
   function automatic void ref_model(input logic [26:0] v, output logic [31:0] b, output logic o);
      int unsigned x;
      x = 32'(v);
      b = '0;
      o = 1'b0;
      if (x > 32'd99999999) begin
         b = 32'h99999999;
         o = 1'b1;
      end else begin
         for (int i = 0; i < 8; i++) begin
            b[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
         end
      end
   endfunction

   // One conversion: latency, busy window, result, flag, single done pulse
   task automatic conv(input string tag, input logic [26:0] v, input logic [31:0] exp_b,
                       input logic exp_o);
      int lat;
      int nbusy;
      lat   = 0;
      nbusy = 0;
      @(negedge clk);
      bus.bin   = v;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.bin   = ~v;
      if (bus.busy) nbusy++;
      while (!bus.done && lat < 60) begin
         @(negedge clk);
         lat++;
         if (bus.busy) nbusy++;
      end
      check({tag, "_lat"}, lat, 28);
      check({tag, "_busycyc"}, nbusy, 28);
      check({tag, "_bcd"}, bus.bcd, exp_b);
      check({tag, "_ovf"}, bus.ovf, exp_o);
      check({tag, "_busy_end"}, bus.busy, 1'b0);
      @(negedge clk);
      check({tag, "_done_clr"}, bus.done, 1'b0);
   endtask

   initial begin
      logic [31:0] eb;
      logic        eo;
      logic [26:0] v;
      int          cyc;
      int          ndone;
      int          nbusy;

      tests     = 0;
      fails     = 0;
      rs_n      = 1'b1;
      bus.start = 1'b0;
      bus.bin   = '0;
      #1 rs_n = 1'b0;
      #1;
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_bcd", bus.bcd, 32'h0);
      check("rst_ovf", bus.ovf, 1'b0);
      repeat (2) @(negedge clk);
      rs_n = 1'b1;

      conv("zero", 27'd0, 32'h00000000, 1'b0);
      conv("mid", 27'd12345678, 32'h12345678, 1'b0);

      // Result must stay put with no further starts
      cyc   = 0;
      ndone = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.bcd !== 32'h12345678) cyc++;
         if (bus.done) ndone++;
      end
      check("hold_bcd_changes", cyc, 0);
      check("hold_done_count", ndone, 0);

      // Back-to-back with start held high throughout
      @(negedge clk);
      bus.bin   = 27'd7;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.bin = 27'd805;
      cyc = 0;
      while (!bus.done && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      check("b2b_lat1", cyc, 28);
      check("b2b_bcd1", bus.bcd, 32'h00000007);
      check("b2b_ovf1", bus.ovf, 1'b0);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!bus.done && cyc < 60);
      bus.start = 1'b0;
      check("b2b_period", cyc, 29);
      check("b2b_bcd2", bus.bcd, 32'h00000805);
      repeat (3) @(negedge clk);
      check("b2b_idle_after", bus.busy, 1'b0);

      conv("max", 27'd99999999, 32'h99999999, 1'b0);
      conv("over", 27'd100000000, 32'h99999999, 1'b1);
      conv("small", 27'd59, 32'h00000059, 1'b0);

      // Reset at cycle 10 of a conversion
      check("pre_rst_bcd", bus.bcd, 32'h00000059);
      @(negedge clk);
      bus.bin   = 27'd4321;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("pre_rst_busy", bus.busy, 1'b1);
      #1 rs_n = 1'b0;
      #1;
      check("mid_rst_busy", bus.busy, 1'b0);
      check("mid_rst_done", bus.done, 1'b0);
      check("mid_rst_bcd", bus.bcd, 32'h0);
      check("mid_rst_ovf", bus.ovf, 1'b0);
      @(negedge clk);
      rs_n  = 1'b1;
      ndone = 0;
      nbusy = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) ndone++;
         if (bus.busy) nbusy++;
      end
      check("post_rst_done_count", ndone, 0);
      check("post_rst_busy_count", nbusy, 0);
      check("post_rst_bcd", bus.bcd, 32'h0);
      conv("after_rst", 27'd4321, 32'h00004321, 1'b0);

      // Boundary digits and the all-ones input
      conv("one", 27'd1, 32'h00000001, 1'b0);
      conv("nine", 27'd9, 32'h00000009, 1'b0);
      conv("ten", 27'd10, 32'h00000010, 1'b0);
      conv("k99", 27'd99999, 32'h00099999, 1'b0);
      conv("all1", 27'h7FFFFFF, 32'h99999999, 1'b1);

      // Short random sweep against the decimal model
      for (int i = 0; i < 30; i++) begin
         v = 27'($urandom_range(0, 134217727));
         ref_model(v, eb, eo);
         conv("rand", v, eb, eo);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
